// File: rtl/intersection_ctrl.sv
// Two-way intersection controller: demand-driven green handover with yellow and all-red clearance.
// Define INTERSECTION_PED_WALK_EN to add the pedestrian walk phases inside the all-red gaps.
package traffic_light_pkg;
  typedef enum logic [1:0] {RED = 2'd0, YELLOW = 2'd1, GREEN = 2'd2} traffic_light_t;
endpackage

module intersection_ctrl
  import traffic_light_pkg::*;
#(
  parameter int unsigned GREEN_CYCLES  = 8,
  parameter int unsigned YELLOW_CYCLES = 3,
  parameter int unsigned ALLRED_CYCLES = 1,
  parameter int unsigned WALK_CYCLES   = 6
) (
  input  logic           clk,
  input  logic           asyn_n_reset,
  input  logic           en,
  input  logic           ns_car,
  input  logic           ew_car,
  input  logic           ped_btn,
  output traffic_light_t ns_light,
  output traffic_light_t ew_light,
  output logic           walk
);

`ifdef INTERSECTION_PED_WALK_EN
  typedef enum logic [2:0] {
    NS_GREEN, NS_YELLOW, ALLRED_A, EW_GREEN, EW_YELLOW, ALLRED_B, PED_WALK_A, PED_WALK_B
  } state_t;
  localparam logic [7:0] WALK_LAST = 8'(WALK_CYCLES - 1);
`else
  typedef enum logic [2:0] {
    NS_GREEN, NS_YELLOW, ALLRED_A, EW_GREEN, EW_YELLOW, ALLRED_B
  } state_t;
  localparam int unsigned unused_walk_cycles = WALK_CYCLES;
  logic unused_ped_btn;
  assign unused_ped_btn = ped_btn;
`endif

  localparam logic [7:0] GREEN_LAST  = 8'(GREEN_CYCLES - 1);
  localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_CYCLES - 1);
  localparam logic [7:0] ALLRED_LAST = 8'(ALLRED_CYCLES - 1);

  state_t         state_q, state_d;
  logic [7:0]     timer_q, timer_d;
  logic           ns_req_q, ns_req_d;
  logic           ew_req_q, ew_req_d;
  traffic_light_t ns_light_q, ns_light_d;
  traffic_light_t ew_light_q, ew_light_d;
  logic           walk_q, walk_d;
  logic           entry;
`ifdef INTERSECTION_PED_WALK_EN
  logic           ped_req_q, ped_req_d;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      NS_GREEN:   if (en && timer_q >= GREEN_LAST && ew_req_q) state_d = NS_YELLOW;
      NS_YELLOW:  if (en && timer_q == YELLOW_LAST) state_d = ALLRED_A;
      EW_GREEN:   if (en && timer_q >= GREEN_LAST && ns_req_q) state_d = EW_YELLOW;
      EW_YELLOW:  if (en && timer_q == YELLOW_LAST) state_d = ALLRED_B;
`ifdef INTERSECTION_PED_WALK_EN
      ALLRED_A:   if (en && timer_q == ALLRED_LAST) state_d = ped_req_q ? PED_WALK_A : EW_GREEN;
      ALLRED_B:   if (en && timer_q == ALLRED_LAST) state_d = ped_req_q ? PED_WALK_B : NS_GREEN;
      PED_WALK_A: if (en && timer_q == WALK_LAST) state_d = EW_GREEN;
      PED_WALK_B: if (en && timer_q == WALK_LAST) state_d = NS_GREEN;
`else
      ALLRED_A:   if (en && timer_q == ALLRED_LAST) state_d = EW_GREEN;
      ALLRED_B:   if (en && timer_q == ALLRED_LAST) state_d = NS_GREEN;
`endif
      default:    state_d = NS_GREEN;
    endcase

    entry = (state_d != state_q);
    if (entry)                         timer_d = 8'd0;
    else if (en && timer_q != 8'hFF)   timer_d = timer_q + 8'd1;
    else                               timer_d = timer_q;

    // Clear on phase entry takes priority over a sensor hit in the same cycle.
    ns_req_d = (entry && state_d == NS_GREEN) ? 1'b0 : (ns_req_q | ns_car);
    ew_req_d = (entry && state_d == EW_GREEN) ? 1'b0 : (ew_req_q | ew_car);
`ifdef INTERSECTION_PED_WALK_EN
    ped_req_d = (entry && (state_d == PED_WALK_A || state_d == PED_WALK_B)) ? 1'b0
                                                                          : (ped_req_q | ped_btn);
`endif

    ns_light_d = RED;
    ew_light_d = RED;
    walk_d     = 1'b0;
    case (state_d)
      NS_GREEN:   ns_light_d = GREEN;
      NS_YELLOW:  ns_light_d = YELLOW;
      EW_GREEN:   ew_light_d = GREEN;
      EW_YELLOW:  ew_light_d = YELLOW;
`ifdef INTERSECTION_PED_WALK_EN
      PED_WALK_A, PED_WALK_B: walk_d = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge asyn_n_reset) begin
    if (!asyn_n_reset) begin
      state_q    <= NS_GREEN;
      timer_q    <= 8'd0;
      ns_req_q   <= 1'b0;
      ew_req_q   <= 1'b0;
      ns_light_q <= GREEN;
      ew_light_q <= RED;
      walk_q     <= 1'b0;
`ifdef INTERSECTION_PED_WALK_EN
      ped_req_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ns_req_q   <= ns_req_d;
      ew_req_q   <= ew_req_d;
      ns_light_q <= ns_light_d;
      ew_light_q <= ew_light_d;
      walk_q     <= walk_d;
`ifdef INTERSECTION_PED_WALK_EN
      ped_req_q  <= ped_req_d;
`endif
    end
  end

  assign ns_light = ns_light_q;
  assign ew_light = ew_light_q;
  assign walk     = walk_q;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Self-checking bench for intersection_ctrl: directed scenarios plus randomized traffic
// checked against a phase/duration table model.
module tb_intersection_ctrl;
  import traffic_light_pkg::*;

  localparam int G = 4, Y = 2, A = 1, W = 3;
`ifdef INTERSECTION_PED_WALK_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif
  localparam int P_NSG = 0, P_NSY = 1, P_ARA = 2, P_EWG = 3, P_EWY = 4, P_ARB = 5,
                 P_PWA = 6, P_PWB = 7;

  logic clk = 1'b0, asyn_n_reset = 1'b0, en = 1'b0, ns_car = 1'b0, ew_car = 1'b0, ped_btn = 1'b0;
  traffic_light_t ns_light, ew_light;
  logic walk;

  int n_cmp = 0, n_bad = 0;
  int m_ph, m_el;
  bit m_nsr, m_ewr, m_pedr;

  intersection_ctrl #(
    .GREEN_CYCLES(G), .YELLOW_CYCLES(Y), .ALLRED_CYCLES(A), .WALK_CYCLES(W)
  ) dut (
    .clk(clk), .asyn_n_reset(asyn_n_reset), .en(en), .ns_car(ns_car), .ew_car(ew_car),
    .ped_btn(ped_btn), .ns_light(ns_light), .ew_light(ew_light), .walk(walk)
  );

  always #5 clk = ~clk;

  // Reference model: each phase is a lamp pattern, a fixed duration and a successor.
  function automatic logic [4:0] lamps(input int p);
    case (p)
      P_NSG:        return {GREEN,  RED,    1'b0};
      P_NSY:        return {YELLOW, RED,    1'b0};
      P_EWG:        return {RED,    GREEN,  1'b0};
      P_EWY:        return {RED,    YELLOW, 1'b0};
      P_PWA, P_PWB: return {RED,    RED,    1'b1};
      default:      return {RED,    RED,    1'b0};
    endcase
  endfunction

  function automatic int dur(input int p);
    case (p)
      P_NSY, P_EWY: return Y;
      P_ARA, P_ARB: return A;
      default:      return W;
    endcase
  endfunction

  function automatic int succ(input int p);
    case (p)
      P_NSY:   return P_ARA;
      P_ARA:   return (PED_EN && m_pedr) ? P_PWA : P_EWG;
      P_PWA:   return P_EWG;
      P_EWY:   return P_ARB;
      P_ARB:   return (PED_EN && m_pedr) ? P_PWB : P_NSG;
      default: return P_NSG;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = P_NSG; m_el = 0; m_nsr = 0; m_ewr = 0; m_pedr = 0;
  endtask

  task automatic model_step(input bit e, input bit n, input bit w, input bit p);
    int nxt;
    nxt = m_ph;
    if (e) begin
      if (m_ph == P_NSG)      begin if (m_el >= G - 1 && m_ewr) nxt = P_NSY; end
      else if (m_ph == P_EWG) begin if (m_el >= G - 1 && m_nsr) nxt = P_EWY; end
      else if (m_el == dur(m_ph) - 1) nxt = succ(m_ph);
    end
    m_nsr  = (nxt == P_NSG && m_ph != P_NSG) ? 1'b0 : (m_nsr | n);
    m_ewr  = (nxt == P_EWG && m_ph != P_EWG) ? 1'b0 : (m_ewr | w);
    m_pedr = PED_EN && (((nxt == P_PWA || nxt == P_PWB) && nxt != m_ph) ? 1'b0 : (m_pedr | p));
    if (nxt != m_ph) m_el = 0;
    else if (e && m_el < 255) m_el = m_el + 1;
    m_ph = nxt;
  endtask

  task automatic tick(input bit e, input bit n, input bit w, input bit p);
    en = e; ns_car = n; ew_car = w; ped_btn = p;
    @(posedge clk);
    model_step(e, n, w, p);
    @(negedge clk);
  endtask

  // Called at a falling edge: pulse reset and leave the bench at the start of cycle 0.
  task automatic do_reset();
    en = 1'b1; ns_car = 1'b0; ew_car = 1'b0; ped_btn = 1'b0;
    asyn_n_reset = 1'b0;
    #1 asyn_n_reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    en = 1'b1; ns_car = 1'b1; ew_car = 1'b1; ped_btn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({ns_light, ew_light, walk} !== {GREEN, RED, 1'b0}) begin
        n_bad++;
        $display("FAIL reset_hold k=%0d: got %b, want %b", k, {ns_light, ew_light, walk},
                 {GREEN, RED, 1'b0});
      end
    end
    do_reset();
    n_cmp++;
    if ({ns_light, ew_light, walk} !== lamps(P_NSG)) begin
      n_bad++;
      $display("FAIL reset_release: got %b, want %b", {ns_light, ew_light, walk}, lamps(P_NSG));
    end
  endtask

  task automatic test_idle();
    do_reset();
    for (int k = 0; k < 100; k++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({ns_light, ew_light, walk} !== {GREEN, RED, 1'b0}) begin
        n_bad++;
        $display("FAIL idle k=%0d: got %b, want %b", k, {ns_light, ew_light, walk},
                 {GREEN, RED, 1'b0});
      end
    end
  endtask

  task automatic test_handover();
    int exp_ph[10] = '{P_NSG, P_NSG, P_NSG, P_NSG, P_NSY, P_NSY, P_ARA, P_EWG, P_EWG, P_EWG};
    do_reset();
    for (int k = 0; k < 10; k++) begin
      n_cmp++;
      if ({ns_light, ew_light, walk} !== lamps(exp_ph[k])) begin
        n_bad++;
        $display("FAIL handover cycle=%0d: got %b, want %b", k, {ns_light, ew_light, walk},
                 lamps(exp_ph[k]));
      end
      tick(1'b1, 1'b0, k == 1, 1'b0);
    end
  endtask

  task automatic test_ped();
    int exp_ph[12];
    if (PED_EN) exp_ph = '{P_NSG, P_NSG, P_NSG, P_NSG, P_NSY, P_NSY, P_ARA,
                           P_PWA, P_PWA, P_PWA, P_EWG, P_EWG};
    else        exp_ph = '{P_NSG, P_NSG, P_NSG, P_NSG, P_NSY, P_NSY, P_ARA,
                           P_EWG, P_EWG, P_EWG, P_EWG, P_EWG};
    do_reset();
    for (int k = 0; k < 12; k++) begin
      n_cmp++;
      if ({ns_light, ew_light, walk} !== lamps(exp_ph[k])) begin
        n_bad++;
        $display("FAIL ped cycle=%0d: got %b, want %b", k, {ns_light, ew_light, walk},
                 lamps(exp_ph[k]));
      end
      tick(1'b1, 1'b0, k == 1, k == 1);
    end
  endtask

  task automatic test_freeze();
    int yel, grn, guard;
    do_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    guard = 0;
    while (ns_light !== YELLOW && guard < 20) begin tick(1'b1, 1'b0, 1'b0, 1'b0); guard++; end
    yel = 0;
    guard = 0;
    while (ns_light === YELLOW && guard < 20) begin
      yel++;
      guard++;
      if (guard <= 3) tick(1'b0, guard == 2, 1'b0, 1'b0);
      else            tick(1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({ns_light, ew_light, walk} !== lamps(m_ph)) begin
        n_bad++;
        $display("FAIL freeze_track: got %b, want %b", {ns_light, ew_light, walk}, lamps(m_ph));
      end
    end
    n_cmp++;
    if (yel != 5) begin
      n_bad++;
      $display("FAIL freeze_yellow_len: got %0d cycles, want 5", yel);
    end
    guard = 0;
    while (ew_light !== GREEN && guard < 20) begin tick(1'b1, 1'b0, 1'b0, 1'b0); guard++; end
    grn = 0;
    guard = 0;
    while (ew_light === GREEN && guard < 20) begin
      grn++; guard++;
      tick(1'b1, 1'b0, 1'b0, 1'b0);
    end
    n_cmp++;
    if (grn != G || ew_light !== YELLOW) begin
      n_bad++;
      $display("FAIL freeze_ns_req_kept: ew green %0d cycles then ew=%0d, want %0d then %0d",
               grn, ew_light, G, YELLOW);
    end
  endtask

  task automatic test_async_reset();
    int grn, guard;
    do_reset();
    guard = 0;
    while (ew_light !== YELLOW && guard < 40) begin tick(1'b1, 1'b1, 1'b1, 1'b0); guard++; end
    n_cmp++;
    if (ew_light !== YELLOW) begin
      n_bad++;
      $display("FAIL async_reach_ew_yellow: got ew=%0d, want %0d", ew_light, YELLOW);
    end
    #2 asyn_n_reset = 1'b0;
    #1;
    n_cmp++;
    if ({ns_light, ew_light, walk} !== {GREEN, RED, 1'b0}) begin
      n_bad++;
      $display("FAIL async_immediate: got %b, want %b", {ns_light, ew_light, walk},
               {GREEN, RED, 1'b0});
    end
    #1 asyn_n_reset = 1'b1;
    model_reset();
    grn = 0;
    guard = 0;
    while (ns_light === GREEN && guard < 20) begin
      grn++; guard++;
      tick(1'b1, 1'b0, guard == 1, 1'b0);
      n_cmp++;
      if ({ns_light, ew_light, walk} !== lamps(m_ph)) begin
        n_bad++;
        $display("FAIL async_track: got %b, want %b", {ns_light, ew_light, walk}, lamps(m_ph));
      end
    end
    n_cmp++;
    if (grn != G) begin
      n_bad++;
      $display("FAIL async_full_green: got %0d green cycles, want %0d", grn, G);
    end
  endtask

  task automatic test_clear_wins();
    int guard;
    do_reset();
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    guard = 0;
    while (ew_light !== GREEN && guard < 20) begin tick(1'b1, 1'b0, 1'b0, 1'b0); guard++; end
    guard = 0;
    while (ns_light !== GREEN && guard < 30) begin tick(1'b1, 1'b1, 1'b0, 1'b0); guard++; end
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    guard = 0;
    while (ew_light !== GREEN && guard < 30) begin tick(1'b1, 1'b0, 1'b0, 1'b0); guard++; end
    n_cmp++;
    if (ew_light !== GREEN) begin
      n_bad++;
      $display("FAIL clear_wins_reach_ew: got ew=%0d, want %0d", ew_light, GREEN);
    end
    for (int k = 0; k < 20; k++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({ns_light, ew_light, walk} !== {RED, GREEN, 1'b0}) begin
        n_bad++;
        $display("FAIL clear_wins_hold k=%0d: got %b, want %b", k, {ns_light, ew_light, walk},
                 {RED, GREEN, 1'b0});
      end
    end
  endtask

  task automatic test_random();
    bit e, n, w, p;
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      e = ($urandom % 6) != 0;
      n = ($urandom % 10) == 0;
      w = ($urandom % 10) == 0;
      p = ($urandom % 14) == 0;
      tick(e, n, w, p);
      n_cmp++;
      if ({ns_light, ew_light, walk} !== lamps(m_ph)) begin
        n_bad++;
        $display("FAIL random k=%0d: got %b, want %b (phase %0d)", k, {ns_light, ew_light, walk},
                 lamps(m_ph), m_ph);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle();
    test_handover();
    test_ped();
    test_freeze();
    test_async_reset();
    test_clear_wins();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
